// File: rtl/module_pipelined_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
// The slave side is the arithmetic block; the master side is its user.
interface module_pipelined_addsub_if #(
    parameter int WIDTH = 64
);

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             carry_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             overflow_o;

    modport slave (
        input  valid_i,
        input  a_i,
        input  b_i,
        input  carry_i,
        input  sub_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output sum_o,
        output carry_o,
        output overflow_o
    );

    modport master (
        output valid_i,
        output a_i,
        output b_i,
        output carry_i,
        output sub_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  sum_o,
        input  carry_o,
        input  overflow_o
    );

endinterface

// File: rtl/module_pipelined_addsub.sv
// WIDTH-bit add/subtract resolved one SW-bit slice per stage, with the carry
// registered between slices and a ready/valid handshake that stalls the whole pipe.
module module_pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    module_pipelined_addsub_if.slave bus
);

    localparam int SW  = WIDTH / STAGES;
    localparam int LST = STAGES - 1;
    localparam int MSB = WIDTH - 1;

    logic             en;

    logic [WIDTH-1:0] stgA     [STAGES];
    logic [WIDTH-1:0] stgB     [STAGES];
    logic [WIDTH-1:0] stgSum   [STAGES];
    logic             stgCarry [STAGES];
    logic             stgValid [STAGES];

    logic [SW:0]      sliceRes [STAGES];
    logic [WIDTH-1:0] sum_d    [STAGES];
    logic             carry_d  [STAGES];
    logic             ovf_d;

    logic [WIDTH-1:0] opA_q    [STAGES];
    logic [WIDTH-1:0] opB_q    [STAGES];
    logic [WIDTH-1:0] sum_q    [STAGES];
    logic             carry_q  [STAGES];
    logic             valid_q  [STAGES];
    logic             ovf_q;

    // Stage 0 sees the prepared operands; later stages see the previous stage's registers.
    always_comb begin
        stgA[0]     = bus.a_i;
        stgB[0]     = bus.sub_i ? ~bus.b_i : bus.b_i;
        stgSum[0]   = '0;
        stgCarry[0] = bus.carry_i ^ bus.sub_i;
        stgValid[0] = bus.valid_i;
        for (int k = 1; k < STAGES; k++) begin
            stgA[k]     = opA_q[k-1];
            stgB[k]     = opB_q[k-1];
            stgSum[k]   = sum_q[k-1];
            stgCarry[k] = carry_q[k-1];
            stgValid[k] = valid_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sliceRes[k] = {1'b0, stgA[k][k*SW +: SW]}
                        + {1'b0, stgB[k][k*SW +: SW]}
                        + {{SW{1'b0}}, stgCarry[k]};
            sum_d[k]               = stgSum[k];
            sum_d[k][k*SW +: SW]   = sliceRes[k][SW-1:0];
            carry_d[k]             = sliceRes[k][SW];
        end
        // Overflow uses the operand MSBs still travelling with the top slice.
        ovf_d = (stgA[LST][MSB] == stgB[LST][MSB]) && (sum_d[LST][MSB] != stgA[LST][MSB]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k]   <= '0;
                opB_q[k]   <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k]   <= stgA[k];
                opB_q[k]   <= stgB[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= stgValid[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign en             = !valid_q[LST] || bus.ready_i;
    assign bus.ready_o    = en;
    assign bus.valid_o    = valid_q[LST];
    assign bus.sum_o      = sum_q[LST];
    assign bus.carry_o    = carry_q[LST];
    assign bus.overflow_o = ovf_q;

endmodule

// File: doc/module_pipelined_addsub.md
Name: module_pipelined_addsub

Overview:
- Parametrised successor to the single-cycle ripple-carry adder: WIDTH-bit add/subtract split into STAGES equal slices, one slice resolved per pipeline stage.
- Carry is registered between slices, bounding the combinational path to WIDTH/STAGES full-adder bits.
- Ready/valid handshake on both sides with whole-pipeline stall.
- Used as the arithmetic datapath for wide accumulators and ALU front-ends.

Parameters:
- WIDTH, 64, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  1  input operands valid
- ready_o  out  1  block can accept an operand set this cycle
- a_i  in  WIDTH  operand A, unsigned / two's complement
- b_i  in  WIDTH  operand B
- carry_i  in  1  carry-in (add) or borrow-in (sub)
- sub_i  in  1  0: A+B+carry_i; 1: A-B-carry_i
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- sum_o  out  WIDTH  result
- carry_o  out  1  add: carry-out; sub: NOT borrow (1 = no borrow)
- overflow_o  out  1  signed two's-complement overflow of the final result

Behaviour:
- Reset (rst_n_i=0, asynchronous): all stage valid bits, valid_o, sum_o, carry_o, overflow_o cleared to 0 immediately; all slice/carry/skew registers to 0. ready_o=1 after reset.
- Advance enable: en = !valid_o || ready_i. ready_o = en (combinational). When en=0 no register changes, including valid bits (full stall, no bubble collapse).
- Input accept: transfer when valid_i && ready_o. On non-transfer with en=1, a bubble (valid=0) enters stage 0.
- Operand preparation at stage 0: B' = sub_i ? ~b_i : b_i; cin = carry_i XOR sub_i.
- Stage k (0..STAGES-1) computes slice k: {c_k+1, s_k} = A[k*SW +: SW] + B'[k*SW +: SW] + c_k, with c_0 = cin. c_k+1 registered into stage k+1.
- Skew: upper operand slices travel in delay registers until their stage; completed lower result slices travel in deskew registers so all slices of one operation emerge together.
- Latency: exactly STAGES cycles from accepted input to valid_o=1 with no stall; throughput 1 op/cycle when ready_i=1.
- STAGES=1: single registered adder, latency 1.
- carry_o = final slice carry-out. overflow_o = (A[MSB] == B'[MSB]) && (sum_o[MSB] != A[MSB]), computed from the top slice; the top slice keeps the operand MSBs it needs.
- Outputs are registered. While valid_o=1 && ready_i=0, sum_o/carry_o/overflow_o/valid_o hold stable.
- Wrap-around: results are modulo 2^WIDTH; no saturation.
- Reset mid-operation: all in-flight operations are discarded, with no partial results emitted after release.
- Per-operation sub_i/carry_i are captured at accept; changing them while a transfer is in flight has no effect on that transfer.

Test Plan:
- WIDTH=8, STAGES=2: accept A=0x0F, B=0x01, sub=0, cin=0 -> 2 cycles later valid_o=1, sum=0x10, carry=0, ovf=0; exercises the inter-slice carry.
- WIDTH=8, STAGES=2: A=0x7F, B=0x01, add -> sum=0x80, carry=0, ovf=1. A=0xFF, B=0x01 -> sum=0x00, carry=1, ovf=0.
- WIDTH=8, STAGES=4, subtract: A=0x10, B=0x20, cin=0 -> sum=0xF0, carry_o=0 (borrow). A=0x20, B=0x10, cin=1 -> sum=0x0F, carry_o=1.
- Back-to-back stream of 16 random ops, ready_i=1, WIDTH=64, STAGES=4 -> one result per cycle, in order, matching the reference model, first result at cycle 4.
- Backpressure: hold ready_i=0 for 5 cycles with the pipe full -> ready_o=0, outputs frozen. Release -> no loss or duplication; order is preserved.
- Assert rst_n_i=0 asynchronously with 3 ops in flight -> valid_o falls without a clock edge. After release, no stale results appear; a new op completes with correct latency.
